// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: field widths, control-bit positions,
// data-bundle field offsets and the skid stage state encoding.
package pipe_pkg;

  localparam int unsigned WORD_LEN          = 32;
  localparam int unsigned REG_FILE_ADDR_LEN = 5;
  localparam int unsigned EXE_CMD_LEN       = 4;

  // Control bundle bit positions; EXE_CMD occupies the top nibble.
  localparam int unsigned CTRL_MEM_R  = 0;
  localparam int unsigned CTRL_MEM_W  = 1;
  localparam int unsigned CTRL_WB     = 2;
  localparam int unsigned CTRL_BR     = 3;
  localparam int unsigned CTRL_EXE_LO = 4;

  // Data bundle field offsets (LSB of each field).
  localparam int unsigned DATA_DEST_LO  = 0;
  localparam int unsigned DATA_SRC1_LO  = DATA_DEST_LO + REG_FILE_ADDR_LEN;
  localparam int unsigned DATA_SRC2_LO  = DATA_SRC1_LO + REG_FILE_ADDR_LEN;
  localparam int unsigned DATA_STVAL_LO = DATA_SRC2_LO + REG_FILE_ADDR_LEN;
  localparam int unsigned DATA_VAL1_LO  = DATA_STVAL_LO + WORD_LEN;
  localparam int unsigned DATA_VAL2_LO  = DATA_VAL1_LO + WORD_LEN;
  localparam int unsigned DATA_PC_LO    = DATA_VAL2_LO + WORD_LEN;
  localparam int unsigned DATA_BUNDLE_W = DATA_PC_LO + WORD_LEN;

  // Occupancy of the stage: nothing, main slot only, main plus skid slot.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_C  = {W{1'b1}};
  localparam logic [W-1:0] STEP_C = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] value_r;

  // Count requested cycles, clamping at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      value_r <= {W{1'b0}};
    end else if (inc && (value_r != MAX_C)) begin
      value_r <= value_r + STEP_C;
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic inter-stage pipeline register with a two-entry skid buffer.
// in_ready depends only on the state register, so there is no
// combinational path from out_ready back to in_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 143,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_r;
  stage_state_e      state_s;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;

  logic accept_s;
  logic consume_s;
  logic load_main_in_s;
  logic load_main_skid_s;
  logic load_skid_s;
  logic clr_main_s;
  logic stall_s;

  assign in_ready  = (state_r != FULL);
  assign out_valid = (state_r != EMPTY);
  assign accept_s  = in_valid & in_ready;
  assign consume_s = out_valid & out_ready;

  // Next-state and slot-load decisions; flush overrides every transfer.
  always_comb begin
    state_s          = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    clr_main_s       = 1'b0;
    if (flush) begin
      state_s    = EMPTY;
      clr_main_s = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_s        = ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && !consume_s) begin
            state_s     = FULL;
            load_skid_s = 1'b1;
          end else if (consume_s && !accept_s) begin
            state_s    = EMPTY;
            clr_main_s = 1'b1;
          end else if (accept_s && consume_s) begin
            state_s        = ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_s = ONE;
          end
        end
        FULL: begin
          if (consume_s) begin
            state_s          = ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s    = EMPTY;
          clr_main_s = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Main slot; its control is zeroed whenever the slot empties so that
  // bubbles never carry memory or write-back enables downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl_r <= {CTRL_W{1'b0}};
      main_data_r <= {DATA_W{1'b0}};
    end else if (load_main_in_s) begin
      main_ctrl_r <= in_ctrl;
      main_data_r <= in_data;
    end else if (load_main_skid_s) begin
      main_ctrl_r <= skid_ctrl_r;
      main_data_r <= skid_data_r;
    end else if (clr_main_s) begin
      main_ctrl_r <= {CTRL_W{1'b0}};
      main_data_r <= main_data_r;
    end else begin
      main_ctrl_r <= main_ctrl_r;
      main_data_r <= main_data_r;
    end
  end

  // Skid slot catches the entry accepted while the main slot is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ctrl_r <= {CTRL_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
    end else if (load_skid_s) begin
      skid_ctrl_r <= in_ctrl;
      skid_data_r <= in_data;
    end else begin
      skid_ctrl_r <= skid_ctrl_r;
      skid_data_r <= skid_data_r;
    end
  end

  assign out_ctrl = main_ctrl_r;
  assign out_data = main_data_r;

  // Backpressure cycles for performance debug; flush does not clear it.
  assign stall_s = out_valid & ~out_ready;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (stall_s),
    .value(stall_cnt)
  );

endmodule
